// File: rtl/wired_ras.sv
// Speculative return address stack with checkpoint repair on mispredict redirect.
// Updates land one cycle after the request; no backpressure, redirect overrides fetch push/pop.
module wired_ras #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [31:0]      push_addr_i,
  input  logic             pop_i,
  output logic [31:0]      top_o,
  output logic             valid_o,
  output logic [PTR_W-1:0] ptr_o,
  output logic [CNT_W-1:0] cnt_o,
  input  logic             redirect_i,
  input  logic [PTR_W-1:0] redirect_ptr_i,
  input  logic [31:0]      redirect_top_i,
  input  logic [CNT_W-1:0] redirect_cnt_i,
  input  logic [1:0]       redirect_type_i,
  input  logic [31:0]      redirect_pc_i,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LP_P1    = PTR_W'(1);
  localparam logic [CNT_W-1:0] LP_C1    = CNT_W'(1);

  logic [31:0]      r_stk [DEPTH];
  logic [PTR_W-1:0] r_tos;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic [PTR_W-1:0] w_tos_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;
  logic             w_wa_en;
  logic [PTR_W-1:0] w_wa_idx;
  logic [31:0]      w_wa_dat;
  logic             w_wb_en;
  logic [PTR_W-1:0] w_wb_idx;
  logic [31:0]      w_wb_dat;

  // Port A is the checkpoint repair write; port B (push / call link) takes precedence.
  always_comb begin
    w_tos_nxt = r_tos;
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = 1'b0;
    w_wa_en   = 1'b0;
    w_wa_idx  = redirect_ptr_i;
    w_wa_dat  = redirect_top_i;
    w_wb_en   = 1'b0;
    w_wb_idx  = r_tos + LP_P1;
    w_wb_dat  = push_addr_i;
    if (redirect_i) begin
      w_wa_en = 1'b1;
      case (redirect_type_i)
        2'd1: begin
          w_tos_nxt = redirect_ptr_i + LP_P1;
          w_wb_en   = 1'b1;
          w_wb_idx  = redirect_ptr_i + LP_P1;
          w_wb_dat  = redirect_pc_i + 32'd4;
          w_cnt_nxt = (redirect_cnt_i >= LP_DEPTH) ? LP_DEPTH : redirect_cnt_i + LP_C1;
          w_ovf_nxt = (redirect_cnt_i == LP_DEPTH);
        end
        2'd2: begin
          if (redirect_cnt_i != '0) begin
            w_tos_nxt = redirect_ptr_i - LP_P1;
            w_cnt_nxt = redirect_cnt_i - LP_C1;
          end else begin
            w_tos_nxt = redirect_ptr_i;
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_tos_nxt = redirect_ptr_i;
          w_cnt_nxt = redirect_cnt_i;
        end
      endcase
    end else if (push_i && (!pop_i || r_cnt == '0)) begin
      w_tos_nxt = r_tos + LP_P1;
      w_wb_en   = 1'b1;
      w_cnt_nxt = (r_cnt >= LP_DEPTH) ? LP_DEPTH : r_cnt + LP_C1;
      w_ovf_nxt = (r_cnt == LP_DEPTH);
    end else if (push_i && pop_i) begin
      w_wb_en  = 1'b1;
      w_wb_idx = r_tos;
    end else if (pop_i && r_cnt != '0) begin
      w_tos_nxt = r_tos - LP_P1;
      w_cnt_nxt = r_cnt - LP_C1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
      r_tos <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wa_en) r_stk[w_wa_idx] <= w_wa_dat;
      if (w_wb_en) r_stk[w_wb_idx] <= w_wb_dat;
      r_tos <= w_tos_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign top_o      = (r_cnt == '0) ? 32'd0 : r_stk[r_tos];
  assign valid_o    = (r_cnt != '0);
  assign ptr_o      = r_tos;
  assign cnt_o      = r_cnt;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_wired_ras.sv
// Directed bench for wired_ras: per-cycle model comparison plus literal checkpoints.
module tb_wired_ras;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_i = 1'b0;
  logic [31:0] push_addr_i = '0;
  logic        pop_i = 1'b0;
  logic [31:0] top_o;
  logic        valid_o;
  logic [2:0]  ptr_o;
  logic [3:0]  cnt_o;
  logic        redirect_i = 1'b0;
  logic [2:0]  redirect_ptr_i = '0;
  logic [31:0] redirect_top_i = '0;
  logic [3:0]  redirect_cnt_i = '0;
  logic [1:0]  redirect_type_i = '0;
  logic [31:0] redirect_pc_i = '0;
  logic        overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  wired_ras #(.DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_i(push_i), .push_addr_i(push_addr_i), .pop_i(pop_i),
    .top_o(top_o), .valid_o(valid_o), .ptr_o(ptr_o), .cnt_o(cnt_o),
    .redirect_i(redirect_i), .redirect_ptr_i(redirect_ptr_i),
    .redirect_top_i(redirect_top_i), .redirect_cnt_i(redirect_cnt_i),
    .redirect_type_i(redirect_type_i), .redirect_pc_i(redirect_pc_i),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Reference model: a plain array with an explicit top index and occupancy count.
  logic [31:0] m_stk [D];
  int          m_tos, m_cnt, m_p, m_c;
  bit          m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) m_stk[i] = 32'd0;
      m_tos = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      m_ovf = 0;
      if (redirect_i) begin
        m_p = int'(redirect_ptr_i);
        m_c = int'(redirect_cnt_i);
        m_stk[m_p] = redirect_top_i;
        if (redirect_type_i == 2'd1) begin
          m_tos = (m_p + 1) % D;
          m_stk[m_tos] = redirect_pc_i + 32'd4;
          m_cnt = (m_c + 1 > D) ? D : m_c + 1;
          m_ovf = (m_c == D);
        end else if (redirect_type_i == 2'd2) begin
          m_tos = (m_c > 0) ? (m_p + D - 1) % D : m_p;
          m_cnt = (m_c > 0) ? m_c - 1 : 0;
        end else begin
          m_tos = m_p;
          m_cnt = m_c;
        end
      end else if (push_i && (!pop_i || m_cnt == 0)) begin
        m_ovf = (m_cnt == D);
        m_tos = (m_tos + 1) % D;
        m_stk[m_tos] = push_addr_i;
        m_cnt = (m_cnt + 1 > D) ? D : m_cnt + 1;
      end else if (push_i && pop_i) begin
        m_stk[m_tos] = push_addr_i;
      end else if (pop_i && m_cnt > 0) begin
        m_tos = (m_tos + D - 1) % D;
        m_cnt = m_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model.top",   top_o, (m_cnt == 0) ? 32'd0 : m_stk[m_tos]);
      chk("model.valid", {31'd0, valid_o}, (m_cnt != 0) ? 32'd1 : 32'd0);
      chk("model.ptr",   {29'd0, ptr_o}, 32'(m_tos));
      chk("model.cnt",   {28'd0, cnt_o}, 32'(m_cnt));
      chk("model.ovf",   {31'd0, overflow_o}, {31'd0, m_ovf});
    end
  end

  // Applies one fetch-side cycle; returns #1 after the capturing edge.
  task automatic op(input logic ps, input logic [31:0] a, input logic pp);
    push_i = ps; push_addr_i = a; pop_i = pp;
    @(posedge clk); #1;
    push_i = 0; pop_i = 0; push_addr_i = '0;
  endtask

  task automatic redir(input logic [1:0] ty, input logic [2:0] p, input logic [3:0] c,
                       input logic [31:0] top, input logic [31:0] pc, input logic ps);
    redirect_i = 1; redirect_type_i = ty; redirect_ptr_i = p; redirect_cnt_i = c;
    redirect_top_i = top; redirect_pc_i = pc; push_i = ps; push_addr_i = 32'h5555;
    @(posedge clk); #1;
    redirect_i = 0; push_i = 0; push_addr_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".top"}, top_o, 32'd0);
    chk({tag, ".valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, ".ptr"}, {29'd0, ptr_o}, 32'd0);
    chk({tag, ".cnt"}, {28'd0, cnt_o}, 32'd0);
    chk({tag, ".ovf"}, {31'd0, overflow_o}, 32'd0);
  endtask

  initial begin
    #3;
    chk_zero("reset");
    do_reset();

    op(1, 32'h1000, 0); op(1, 32'h2000, 0); op(1, 32'h3000, 0);
    chk("push3.top", top_o, 32'h3000);
    chk("push3.cnt", {28'd0, cnt_o}, 32'd3);
    chk("push3.ptr", {29'd0, ptr_o}, 32'd3);
    op(0, 0, 1); chk("pop1.top", top_o, 32'h2000);
    op(0, 0, 1); chk("pop2.top", top_o, 32'h1000);
    op(0, 0, 1); chk("pop3.top", top_o, 32'h0);
    chk("pop3.valid", {31'd0, valid_o}, 32'd0);
    op(0, 0, 1);
    chk("pop4.ptr", {29'd0, ptr_o}, 32'd0);
    chk("pop4.cnt", {28'd0, cnt_o}, 32'd0);

    for (int k = 1; k <= 9; k++) begin
      op(1, 32'(k * 32'h100), 0);
      chk("ovf.pulse", {31'd0, overflow_o}, (k == 9) ? 32'd1 : 32'd0);
    end
    chk("ovf.cnt", {28'd0, cnt_o}, 32'd8);
    chk("ovf.ptr", {29'd0, ptr_o}, 32'd1);
    chk("ovf.top", top_o, 32'h900);
    for (int i = 0; i < 8; i++) begin
      chk("drain.top", top_o, 32'h900 - 32'(i * 32'h100));
      op(0, 0, 1);
    end
    chk("drain.empty", {31'd0, valid_o}, 32'd0);

    do_reset();
    op(1, 32'h1000, 0);
    op(1, 32'hBAD, 0); op(0, 0, 1); op(1, 32'hDEAD, 1);
    chk("wrong.top", top_o, 32'hDEAD);
    redir(2'd2, 3'd1, 4'd1, 32'h1000, 32'h0, 0);
    chk("rep.ptr", {29'd0, ptr_o}, 32'd0);
    chk("rep.cnt", {28'd0, cnt_o}, 32'd0);
    redir(2'd2, 3'd2, 4'd2, 32'h2222, 32'h0, 0);
    chk("rep.restored", top_o, 32'h1000);

    redir(2'd1, 3'd2, 4'd2, 32'h2000, 32'h8000_0010, 1);
    chk("call.ptr", {29'd0, ptr_o}, 32'd3);
    chk("call.top", top_o, 32'h8000_0014);
    chk("call.cnt", {28'd0, cnt_o}, 32'd3);
    op(0, 0, 1);
    chk("call.pop", top_o, 32'h2000);

    redir(2'd1, 3'd7, 4'd8, 32'h7777, 32'hFFFF_FFFE, 0);
    chk("rcall.ovf", {31'd0, overflow_o}, 32'd1);
    chk("rcall.wrap", top_o, 32'h0000_0002);
    redir(2'd3, 3'd5, 4'd4, 32'hABCD, 32'h0, 1);
    chk("imm.top", top_o, 32'hABCD);
    redir(2'd2, 3'd4, 4'd0, 32'h1, 32'h0, 0);
    chk("ret0.ptr", {29'd0, ptr_o}, 32'd4);

    do_reset();
    for (int k = 1; k <= 4; k++) op(1, 32'(k * 32'h11), 0);
    chk("pre.cnt", {28'd0, cnt_o}, 32'd4);
    push_i = 1; push_addr_i = 32'h99;
    #2; rst_n = 0; #1;
    chk_zero("arst");
    push_i = 0;
    @(negedge clk); rst_n = 1;
    op(1, 32'h44, 0);
    chk("post.top", top_o, 32'h44);
    chk("post.cnt", {28'd0, cnt_o}, 32'd1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wired_ras.md
Name: wired_ras

Overview:
- Speculative return address stack (RAS) on the prediction side of the branch-resolution interface.
- Fetch pushes the link address on predicted calls and pops the predicted target on predicted returns.
- Fetch snapshots ptr_o/top_o/cnt_o with each predicted branch. The backend branch unit sends the snapshot back on a mispredict redirect, and the stack is repaired from it.
- Target-type encoding matches the execute-stage jump unit: 0 none, 1 call, 2 return, 3 immediate/absolute.

Parameters:
- DEPTH, 8, number of 32-bit entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), width of the top-of-stack pointer.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- push_i  in  1  fetch predicted call; push push_addr_i.
- push_addr_i  in  32  link address (call pc + 4).
- pop_i  in  1  fetch predicted return; pop.
- top_o  out  32  predicted return target, stack[tos]; 0 when empty.
- valid_o  out  1  stack non-empty (cnt != 0).
- ptr_o  out  PTR_W  current tos pointer, for the fetch checkpoint.
- cnt_o  out  CNT_W  current occupancy, for the fetch checkpoint.
- redirect_i  in  1  backend mispredict recovery strobe.
- redirect_ptr_i  in  PTR_W  checkpointed tos of the mispredicted branch.
- redirect_top_i  in  32  checkpointed top value of that branch.
- redirect_cnt_i  in  CNT_W  checkpointed occupancy.
- redirect_type_i  in  2  resolved target type of that branch (0/1/2/3).
- redirect_pc_i  in  32  pc of that branch.
- overflow_o  out  1  one-cycle pulse: a push overwrote the oldest entry.

Behaviour:

Reset (asynchronous, rst_n low):
- All entries 0, tos = 0, cnt = 0.
- Therefore top_o = 0, valid_o = 0, ptr_o = 0, cnt_o = 0, overflow_o = 0.
- A reset in the middle of any operation discards it; there is no partial state.

Storage and pointer:
- DEPTH x 32 registers.
- tos is a circular pointer; arithmetic is modulo DEPTH and wraps silently.

Outputs and latency:
- top_o, valid_o, ptr_o, cnt_o are combinational from registered state only. There is no input-to-output path.
- An operation in cycle N is visible in cycle N+1. There is no same-cycle bypass.

Fetch operations (apply only when redirect_i = 0):
- push only: tos <= tos+1; stack[tos+1] <= push_addr_i; cnt <= min(cnt+1, DEPTH).
  - overflow_o = 1 in the next cycle if cnt was DEPTH.
- pop only, cnt != 0: tos <= tos-1; cnt <= cnt-1; the entry itself is not cleared.
- pop only, cnt == 0: ignored; no state change.
- push and pop together (tail call, return-then-call):
  - stack[tos] <= push_addr_i; tos and cnt unchanged.
  - If cnt == 0, this behaves as a push.

Redirect (redirect_i = 1):
- Has absolute priority: push_i/pop_i in the same cycle are dropped.
- Base state: p = redirect_ptr_i, c = redirect_cnt_i.
- stack[p] <= redirect_top_i, repairing an entry that a wrong-path push may have overwritten.
- Then the resolved type is applied in the same cycle:
  - type 0 or 3: tos <= p; cnt <= c.
  - type 1 (call): tos <= p+1; stack[p+1] <= redirect_pc_i + 4 (32-bit wrap); cnt <= min(c+1, DEPTH).
    - The write to stack[p+1] wins over the repair write if DEPTH aliasing makes p+1 == p (not possible for DEPTH >= 2).
    - overflow_o pulses if c == DEPTH.
  - type 2 (return): if c != 0, tos <= p-1 and cnt <= c-1; else tos <= p and cnt <= 0.
- Back-to-back redirects are each fully applied in their own cycle.
- Fetch operations resume the cycle after the redirect.

overflow_o:
- Registered, high for exactly one cycle per overflowing push.
- Otherwise 0.

Test Plan:
- Reset, then push 0x1000, 0x2000, 0x3000 in consecutive cycles -> cycle after the last push: top_o = 0x3000, cnt_o = 3, ptr_o = 3.
- Continuing, pop three times -> top_o shows 0x2000, then 0x1000, then 0 with valid_o = 0. A fourth pop leaves ptr_o = 0, cnt_o = 0.
- DEPTH = 8: push 9 addresses 0x100..0x900 -> overflow_o pulses once after the 9th push; cnt_o = 8; ptr_o wraps to 1; top_o = 0x900.
  - Eight subsequent pops return 0x900..0x200; the wrapped-over 0x100 is lost.
- With 0x1000 pushed (ptr = 1), checkpoint ptr = 1, top = 0x1000, cnt = 1. Wrong-path push 0xBAD and pop, then push 0xDEAD over stack[1] via simultaneous pop+push. Redirect type 2 with the checkpoint -> next cycle: ptr_o = 0, cnt_o = 0, stack[1] restored to 0x1000.
- Redirect type 1, ptr = 2, cnt = 2, top = 0x2000, pc = 0x8000_0010, asserted together with push_i -> push dropped; ptr_o = 3, top_o = 0x8000_0014, cnt_o = 3. One pop then gives top_o = 0x2000.
- Assert rst_n low asynchronously mid-push with a 4-entry stack -> all outputs 0 immediately, without waiting for a clock edge. After release, the first push of 0x44 gives top_o = 0x44, cnt_o = 1.
